// File: rtl/note_track_sequencer.sv
// Beat timer and scrolling note lane feeding the hit-scanning stage.
// Note bits stream from a synchronous song ROM toward the hit-zone cell (bit 37).
module note_track_sequencer #(
    parameter int          SONG_LEN = 64,
    parameter logic [22:0] LIM_SLOW = 23'd6000000,
    parameter logic [22:0] LIM_MED  = 23'd4000000,
    parameter logic [22:0] LIM_FAST = 23'd2500000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [2:0]  mode,
    input  logic [1:0]  speed,
    input  logic        song_data,
    output logic [5:0]  song_addr,
    output logic [22:0] counter,
    output logic [22:0] lim,
    output logic [38:0] padded_notes,
    output logic        beat,
    output logic        song_done
);

    localparam logic [5:0] LAST_ADDR = 6'(SONG_LEN - 1);
    localparam logic [2:0] MODE_CLR  = 3'd1;
    localparam logic [2:0] MODE_PLAY = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_PLAY, S_PAUSE, S_DRAIN, S_DONE
    } state_t;

    state_t      state_q, state_d;
    state_t      resume_q, resume_d;
    state_t      act, nxt;
    logic [22:0] counter_q, counter_d;
    logic [22:0] lim_q, lim_d;
    logic [38:0] notes_q, notes_d;
    logic [5:0]  addr_q, addr_d;
    logic [5:0]  drain_q, drain_d;
    logic        beat_q, beat_d;
    logic        done_q, done_d;
    logic        run, wrap;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            resume_q  <= S_PLAY;
            counter_q <= '0;
            lim_q     <= LIM_MED;
            notes_q   <= '0;
            addr_q    <= '0;
            drain_q   <= '0;
            beat_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            resume_q  <= resume_d;
            counter_q <= counter_d;
            lim_q     <= lim_d;
            notes_q   <= notes_d;
            addr_q    <= addr_d;
            drain_q   <= drain_d;
            beat_q    <= beat_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        resume_d  = resume_q;
        counter_d = counter_q;
        lim_d     = lim_q;
        notes_d   = notes_q;
        addr_d    = addr_q;
        drain_d   = drain_q;
        beat_d    = 1'b0;
        done_d    = done_q;
        // A resuming pause behaves as the state it was paused from.
        act  = (state_q == S_PAUSE) ? resume_q : state_q;
        nxt  = act;
        run  = (state_q == S_PLAY) || (state_q == S_DRAIN) ||
               ((state_q == S_PAUSE) && (mode == MODE_PLAY));
        wrap = (counter_q == lim_q - 23'd1);

        if (mode == MODE_CLR) begin
            state_d   = S_IDLE;
            counter_d = '0;
            notes_d   = '0;
            addr_d    = '0;
            drain_d   = '0;
            done_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (mode == MODE_PLAY) begin
                        state_d   = S_PLAY;
                        counter_d = '0;
                        unique case (speed)
                            2'b00:   lim_d = LIM_SLOW;
                            2'b10:   lim_d = LIM_FAST;
                            default: lim_d = LIM_MED;
                        endcase
                    end
                end
                S_DONE: begin
                    counter_d = '0;
                end
                default: begin
                    if (run) begin
                        counter_d = wrap ? 23'd0 : counter_q + 23'd1;
                        if (wrap) begin
                            beat_d = 1'b1;
                            if (act == S_PLAY) begin
                                notes_d = {notes_q[37:0], song_data};
                                if (addr_q == LAST_ADDR) begin
                                    nxt     = S_DRAIN;
                                    drain_d = '0;
                                end else begin
                                    addr_d = addr_q + 6'd1;
                                end
                            end else begin
                                notes_d = {notes_q[37:0], 1'b0};
                                if (drain_q == 6'd38) begin
                                    nxt    = S_DONE;
                                    done_d = 1'b1;
                                end else begin
                                    drain_d = drain_q + 6'd1;
                                end
                            end
                        end
                        if ((mode != MODE_PLAY) && (nxt != S_DONE)) begin
                            state_d  = S_PAUSE;
                            resume_d = nxt;
                        end else begin
                            state_d = nxt;
                        end
                    end
                end
            endcase
        end
    end

    assign song_addr    = addr_q;
    assign counter      = counter_q;
    assign lim          = lim_q;
    assign padded_notes = notes_q;
    assign beat         = beat_q;
    assign song_done    = done_q;

endmodule

// File: tb/tb_note_track_sequencer.sv
// Directed bench for note_track_sequencer with a 4-bit song ROM (1,0,1,1).
// Short beat periods keep the full song, drain and pause cases within a few thousand cycles.
module tb_note_track_sequencer;

    logic        clk = 1'b0;
    logic        n_rst = 1'b1;
    logic [2:0]  mode = 3'd0;
    logic [1:0]  speed = 2'b10;
    logic        song_data = 1'b0;
    logic [5:0]  song_addr;
    logic [22:0] counter;
    logic [22:0] lim;
    logic [38:0] padded_notes;
    logic        beat;
    logic        song_done;

    int checks = 0;
    int failures = 0;
    int n;
    int bad;
    logic [3:0]  rom [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [38:0] pat;

    note_track_sequencer #(
        .SONG_LEN(4),
        .LIM_SLOW(23'd40),
        .LIM_MED (23'd30),
        .LIM_FAST(23'd20)
    ) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .mode        (mode),
        .speed       (speed),
        .song_data   (song_data),
        .song_addr   (song_addr),
        .counter     (counter),
        .lim         (lim),
        .padded_notes(padded_notes),
        .beat        (beat),
        .song_done   (song_done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) song_data <= rom[song_addr[1:0]][0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_beat(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!beat && cnt < 200);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_counter"}, 64'(counter), 64'd0);
        chk({tag, "_notes"}, 64'(padded_notes), 64'd0);
        chk({tag, "_addr"}, 64'(song_addr), 64'd0);
        chk({tag, "_lim"}, 64'(lim), 64'd30);
        chk({tag, "_beat"}, 64'(beat), 64'd0);
        chk({tag, "_done"}, 64'(song_done), 64'd0);
    endtask

    initial begin
        #2 n_rst = 1'b0;
        #1 chk_reset_vals("rst");
        tick();
        tick();
        n_rst = 1'b1;
        tick();

        // play at fast tempo
        mode = 3'd2;
        speed = 2'b10;
        tick();
        chk("play_lim", 64'(lim), 64'd20);
        chk("play_cnt0", 64'(counter), 64'd0);
        for (int i = 0; i < 19; i++) tick();
        chk("cnt19", 64'(counter), 64'd19);
        chk("nobeat19", 64'(beat), 64'd0);
        tick();
        chk("wrap_cnt", 64'(counter), 64'd0);
        chk("beat1", 64'(beat), 64'd1);
        chk("notes1", 64'(padded_notes), 64'd1);
        chk("addr1", 64'(song_addr), 64'd1);
        tick();
        chk("beat_pulse", 64'(beat), 64'd0);

        wait_beat(n);
        chk("period2", 64'(n), 64'd19);
        chk("notes2", 64'(padded_notes), 64'b10);
        wait_beat(n);
        wait_beat(n);
        chk("period4", 64'(n), 64'd20);
        chk("notes4", 64'(padded_notes), 64'b1011);
        chk("addr4", 64'(song_addr), 64'd3);

        // drain: zeros fed behind the song
        bad = 0;
        for (int b = 5; b <= 38; b++) begin
            wait_beat(n);
            if (n != 20) bad++;
        end
        chk("drain_periods", 64'(bad), 64'd0);
        pat = 39'b1011 << 34;
        chk("notes38", 64'(padded_notes), 64'(pat));
        chk("hit_zone", 64'(padded_notes[37]), 64'd1);
        for (int b = 39; b <= 42; b++) wait_beat(n);
        chk("notes42", 64'(padded_notes), 64'(39'd1 << 38));
        chk("done42", 64'(song_done), 64'd0);
        wait_beat(n);
        chk("done43", 64'(song_done), 64'd1);
        chk("notes43", 64'(padded_notes), 64'd0);
        for (int i = 0; i < 30; i++) tick();
        chk("done_hold", 64'(song_done), 64'd1);
        chk("done_cnt", 64'(counter), 64'd0);
        chk("done_nobeat", 64'(beat), 64'd0);

        // clear and replay, then pause mid-beat
        mode = 3'd1;
        tick();
        chk("clr_done", 64'(song_done), 64'd0);
        chk("clr_addr", 64'(song_addr), 64'd0);
        mode = 3'd2;
        tick();
        wait_beat(n);
        chk("replay_period", 64'(n), 64'd20);
        for (int i = 0; i < 6; i++) tick();
        chk("pre_pause", 64'(counter), 64'd6);
        mode = 3'd3;
        tick();
        for (int i = 0; i < 50; i++) tick();
        chk("pause_cnt", 64'(counter), 64'd7);
        chk("pause_notes", 64'(padded_notes), 64'd1);
        mode = 3'd2;
        wait_beat(n);
        chk("resume_gap", 64'(n), 64'd13);
        chk("resume_notes", 64'(padded_notes), 64'b10);

        // clear on the exact wrap cycle
        for (int i = 0; i < 19; i++) tick();
        chk("pre_clr", 64'(counter), 64'd19);
        mode = 3'd1;
        tick();
        chk("clr_cnt", 64'(counter), 64'd0);
        chk("clr_notes", 64'(padded_notes), 64'd0);
        chk("clr_addr2", 64'(song_addr), 64'd0);
        chk("clr_beat", 64'(beat), 64'd0);

        // tempo is latched only on entering play
        mode = 3'd2;
        speed = 2'b10;
        tick();
        speed = 2'b00;
        for (int i = 0; i < 5; i++) tick();
        chk("lim_held", 64'(lim), 64'd20);
        mode = 3'd1;
        tick();
        mode = 3'd2;
        tick();
        chk("lim_slow", 64'(lim), 64'd40);
        wait_beat(n);
        chk("slow_period", 64'(n), 64'd40);
        mode = 3'd1;
        tick();
        speed = 2'b11;
        mode = 3'd2;
        tick();
        chk("lim_med", 64'(lim), 64'd30);
        wait_beat(n);
        for (int i = 0; i < 5; i++) tick();

        // async reset mid-song
        #2 n_rst = 1'b0;
        #1 chk_reset_vals("midrst");
        tick();
        n_rst = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
